bp_fe_mem_sched: RTL

- Command scheduler in front of the FE memory stage (ITLB + I$ pipeline). Arbitrates between the PC-gen fetch stream and BE-originated maintenance commands (ITLB fill, ITLB fence, icache fence).
- Tracks fetches in the 2-cycle pipeline and generates the poison signal.
- On an I$ miss, parks the missing fetch, waits for the LCE fill to complete, then replays the fetch itself.

---
 rtl/bp_fe_mem_sched_pkg.sv | 44 ++++
 rtl/bp_fe_mem_sched_pipe.sv | 36 +++
 rtl/bp_fe_mem_sched.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/bp_fe_mem_sched_pkg.sv
// Shared types for the FE memory-stage command scheduler.
// Holds the command and response layouts and the scheduler state encoding.
package bp_fe_mem_sched_pkg;

    localparam int vaddr_width_p = 39;
    localparam int vtag_width_p  = 27;
    localparam int ptag_width_p  = 28;
    localparam int instr_width_p = 32;

    typedef enum logic [1:0] {
        e_fe_op_fetch,
        e_fe_op_tlb_fill,
        e_fe_op_tlb_fence,
        e_fe_op_icache_fence
    } bp_fe_mem_op_e;

    typedef struct packed {
        logic [vtag_width_p-1:0] vtag;
        logic [ptag_width_p-1:0] ptag;
        logic                    uncached;
    } bp_fe_tlb_fill_s;

    typedef struct packed {
        bp_fe_mem_op_e            op;
        logic [vaddr_width_p-1:0] vaddr;
        bp_fe_tlb_fill_s          fill;
    } bp_fe_mem_cmd_s;

    typedef struct packed {
        logic [vaddr_width_p-1:0] vaddr;
        logic [instr_width_p-1:0] data;
        logic                     itlb_miss;
        logic                     icache_miss;
        logic                     instr_page_fault;
        logic                     instr_access_fault;
    } bp_fe_mem_resp_s;

    typedef enum logic [1:0] {
        e_sched_ready,
        e_sched_drain,
        e_sched_miss_wait
    } bp_fe_mem_sched_state_e;

endpackage

// File: rtl/bp_fe_mem_sched_pipe.sv
// Two-stage shadow of fetches travelling through the ITLB/I$ pipeline.
// A kill drops the stage1 entry so it never becomes a stage2 (response-cycle) entry.
module bp_fe_mem_sched_pipe
    import bp_fe_mem_sched_pkg::*;
(
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           issue_v,
    input  bp_fe_mem_cmd_s issue_cmd,
    input  logic           kill,
    output logic           stage1_v,
    output logic           stage2_v,
    output bp_fe_mem_cmd_s stage2_cmd
);

    bp_fe_mem_cmd_s stage1_cmd;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stage1_v <= 1'b0;
            stage2_v <= 1'b0;
        end else begin
            stage1_v <= issue_v;
            stage2_v <= stage1_v & ~kill;
        end
    end

    // Command shadows carry no reset; they are only meaningful under their valids.
    always_ff @(posedge clk_i) begin
        if (issue_v) begin
            stage1_cmd <= issue_cmd;
        end
        stage2_cmd <= stage1_cmd;
    end

endmodule

// File: rtl/bp_fe_mem_sched.sv
// Arbitrates fetch and maintenance commands into the FE mem stage, tracks
// in-flight fetches, poisons on redirect/miss, and replays a missing fetch.
module bp_fe_mem_sched
    import bp_fe_mem_sched_pkg::*;
#(
    parameter int mem_cmd_width_lp  = $bits(bp_fe_mem_cmd_s),
    parameter int mem_resp_width_lp = $bits(bp_fe_mem_resp_s)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic [mem_cmd_width_lp-1:0]  fetch_cmd_i,
    input  logic                         fetch_v_i,
    output logic                         fetch_yumi_o,

    input  logic [mem_cmd_width_lp-1:0]  maint_cmd_i,
    input  logic                         maint_v_i,
    output logic                         maint_yumi_o,

    input  logic                         redirect_i,

    output logic [mem_cmd_width_lp-1:0]  mem_cmd_o,
    output logic                         mem_cmd_v_o,
    input  logic                         mem_cmd_yumi_i,
    output logic                         mem_poison_o,

    input  logic [mem_resp_width_lp-1:0] mem_resp_i,
    input  logic                         mem_resp_v_i,
    input  logic                         cache_req_complete_i,

    output logic [mem_resp_width_lp-1:0] fetch_resp_o,
    output logic                         fetch_resp_v_o,
    output logic                         busy_o
);

    bp_fe_mem_sched_state_e state_r, state_n;
    logic                   replay_v_r, replay_v_n;
    logic                   complete_r, complete_n;
    logic                   init_r;
    bp_fe_mem_cmd_s         replay_cmd_r;

    bp_fe_mem_resp_s        resp;
    logic                   out_en;
    logic                   miss_resp, miss_park;
    logic                   complete, replay_live;
    logic                   replay_sel, maint_sel, fetch_sel;
    logic                   replay_yumi;
    logic                   stage1_v, stage2_v;
    bp_fe_mem_cmd_s         stage2_cmd;
    bp_fe_mem_cmd_s         issue_cmd;

    assign resp = mem_resp_i;

    // Outputs are held quiet while in reset and for one cycle afterwards.
    assign out_en = ~reset_i & ~init_r;

    assign miss_resp   = mem_resp_v_i & resp.icache_miss;
    assign miss_park   = out_en & miss_resp & ~redirect_i & (state_r != e_sched_miss_wait);
    assign complete    = cache_req_complete_i | complete_r;
    assign replay_live = replay_v_r & ~redirect_i;

    assign replay_sel = (state_r == e_sched_miss_wait) & replay_live & complete;
    assign maint_sel  = (state_r == e_sched_drain) & maint_v_i & ~stage1_v & ~stage2_v;
    assign fetch_sel  = (state_r == e_sched_ready) & fetch_v_i & ~maint_v_i
                      & ~redirect_i & ~miss_resp;

    assign mem_cmd_v_o  = out_en & (replay_sel | maint_sel | fetch_sel);
    assign fetch_yumi_o = out_en & mem_cmd_yumi_i & fetch_sel;
    assign maint_yumi_o = out_en & mem_cmd_yumi_i & maint_sel;
    assign replay_yumi  = out_en & mem_cmd_yumi_i & replay_sel;

    always_comb begin
        mem_cmd_o = '0;
        if (out_en) begin
            if (replay_sel) begin
                mem_cmd_o = replay_cmd_r;
            end else if (maint_sel) begin
                mem_cmd_o = maint_cmd_i;
            end else if (fetch_sel) begin
                mem_cmd_o = fetch_cmd_i;
            end
        end
    end

    assign mem_poison_o   = out_en & (redirect_i | miss_resp);
    assign fetch_resp_v_o = out_en & mem_resp_v_i & ~resp.icache_miss & ~redirect_i;
    assign fetch_resp_o   = out_en ? resp : '0;
    assign busy_o         = out_en & ((state_r != e_sched_ready) | stage1_v | stage2_v);

    assign issue_cmd = replay_sel ? replay_cmd_r : bp_fe_mem_cmd_s'(fetch_cmd_i);

    bp_fe_mem_sched_pipe pipe (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .issue_v    (fetch_yumi_o | replay_yumi),
        .issue_cmd  (issue_cmd),
        .kill       (mem_poison_o),
        .stage1_v   (stage1_v),
        .stage2_v   (stage2_v),
        .stage2_cmd (stage2_cmd)
    );

    always_comb begin
        state_n    = state_r;
        replay_v_n = replay_v_r;
        complete_n = complete_r;
        case (state_r)
            e_sched_ready: begin
                if (miss_park) begin
                    state_n = e_sched_miss_wait;
                end else if (maint_v_i) begin
                    state_n = e_sched_drain;
                end
            end
            e_sched_drain: begin
                if (miss_park) begin
                    state_n = e_sched_miss_wait;
                end else if (!maint_v_i) begin
                    state_n = e_sched_ready;
                end
            end
            e_sched_miss_wait: begin
                // The LCE fill must finish even when a redirect has dropped the replay.
                if (redirect_i) begin
                    replay_v_n = 1'b0;
                end
                if (complete && !replay_live) begin
                    state_n    = e_sched_ready;
                    replay_v_n = 1'b0;
                    complete_n = 1'b0;
                end else if (replay_yumi) begin
                    state_n    = maint_v_i ? e_sched_drain : e_sched_ready;
                    replay_v_n = 1'b0;
                    complete_n = 1'b0;
                end else if (complete) begin
                    complete_n = 1'b1;
                end
            end
            default: begin
                state_n = e_sched_ready;
            end
        endcase
        if (miss_park) begin
            replay_v_n = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_sched_ready;
            replay_v_r <= 1'b0;
            complete_r <= 1'b0;
            init_r     <= 1'b1;
        end else begin
            state_r    <= state_n;
            replay_v_r <= replay_v_n;
            complete_r <= complete_n;
            init_r     <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (miss_park) begin
            replay_cmd_r <= stage2_cmd;
        end
    end

endmodule
